gray_ptr_sync: RTL and testbench
================================

# gray_ptr_sync

Parametrised multi-channel synchroniser for Gray-coded FIFO pointers crossing into the `clk` domain. It samples `CHANNELS` independent `WIDTH`-bit Gray pointers through a `STAGES`-deep flop chain and presents the synchronised Gray value. Optionally, it also presents a registered binary decode and a per-channel update strobe. It sits on the read side (write pointer in) or the write side (read pointer in) of the CDC FIFO and replaces the fixed single-bit two-flop synchroniser.

## Interface
- `WIDTH`, 4, bits per pointer (Gray), legal range 2..16
- `STAGES`, 2, synchroniser flop depth, legal range 2..4
- `CHANNELS`, 1, number of independent pointers, legal range 1..8
- `clk`  in  1  destination-domain clock
- `rst`  in  1  asynchronous, active-low reset
- `clr`  in  1  synchronous clear, active-high, `clk` domain
- `iptr_gray`  in  CHANNELS*WIDTH  source-domain Gray pointers; channel c at `[c*WIDTH +: WIDTH]`; each must be driven straight from a source-domain flop
- `optr_gray`  out  CHANNELS*WIDTH  synchronised Gray pointers
- `optr_bin`  out  CHANNELS*WIDTH  binary decode of `optr_gray`, registered
- `upd`  out  CHANNELS  one-cycle strobe per channel when that channel's output value changes

## Operation
- Reset: while `rst`=0, all chain flops, `optr_gray`, `optr_bin` and `upd` are 0. Reset is asserted asynchronously and released synchronously, outside this block.
- Each bit of each channel passes through its own `STAGES`-flop chain. There is no logic between stages.
- The last stage drives `optr_gray` directly.
- Decode: `bin[W-1] = gray[W-1]`; `bin[i] = bin[i+1] ^ gray[i]`. The decode is registered, so `optr_bin` lags `optr_gray` by one cycle.
- `upd[c]` = 1 for exactly one cycle when the registered output of channel c (binary when decode is built, Gray otherwise) differs from its value on the previous cycle.
- `upd[c]` is aligned with the cycle in which the new value first appears.
- The first post-reset transition away from 0 produces an `upd`.
- `clr`=1 at an edge sets every stage and output to 0 and forces `upd` to 0 on that edge. The chain refills from `iptr_gray` after `clr` drops. `clr` has priority over data.
- Wrap-around: Gray `1000` followed by `0000` (WIDTH=4) decodes as 15 followed by 0, with a single `upd`. No special handling is needed.
- The synchronised pointer may skip values when the source clock is faster. The block passes skips unmodified; the FIFO full/empty logic tolerates them.
- Channels are fully independent. Simultaneous updates on several channels each raise their own `upd` bit in the same cycle.
- `STAGES` or `WIDTH` outside its legal range is an elaboration error.

## Timing
- A source change captured by the first stage at edge k appears on `optr_gray` after edge k+STAGES-1.
- The same change appears on `optr_bin` and `upd` one edge later, at k+STAGES.
- Because a bit can go metastable, a change can additionally slip one cycle. The bench must accept a latency of L or L+1.
- Minimum synchroniser latency with defaults: 2 cycles to `optr_gray`, 3 cycles to `optr_bin`.
- `clr` takes effect at the edge where it is sampled high. Outputs are 0 from that edge on.
- Nothing is combinational from input to output; every output is a flop.

## Configuration
- Macro: `GRAY_PTR_SYNC_BIN_EN`.
- Defined: the decode register is built, `optr_bin` is valid, and `upd` compares binary values with latency STAGES+1 (edge k+STAGES).
- Undefined: no decode logic is built and `optr_bin` is tied to 0. `upd` compares `optr_gray` against its previous value and is registered, so it still lands one edge after the new value appears on `optr_gray`.

## Structure
- Package `gray_ptr_sync_pkg` contains:
  - functions `gray2bin` and `bin2gray` (`bin2gray` is shared with the FIFO pointer logic);
  - constants `SYNC_STAGES_MIN`=2, `SYNC_STAGES_MAX`=4, `SYNC_WIDTH_MAX`=16.
- Sub-module `sync_chain`: one vector of N-stage flops with async active-low reset and sync clear. `gray_ptr_sync` instantiates it once per channel.
- The chain flops carry the team's ASYNC_REG/false-path attribute on the first stage.

## Test plan
- Reset mid-stream: drive `iptr_gray`=`0110` (WIDTH=4), assert `rst`=0 asynchronously -> all outputs 0 immediately. Release reset -> `optr_gray`=`0110` after STAGES cycles, `optr_bin`=4 and `upd`=1 one cycle later.
- Full Gray count: count 0..15 and wrap, one step every 3 `clk` cycles -> `optr_bin` follows 0..15,0 with 16 `upd` pulses and no glitch values.
- STAGES=3, then 4: single-step input -> `optr_gray` latency measured as 3 (resp. 4) cycles; `optr_bin` and `upd` land one edge later.
- CHANNELS=2, both channels change in the same cycle -> `upd`=`11` for exactly one cycle; `optr_bin` channel 1 = 5 and channel 0 = 9 as driven.
- `clr` pulse while `optr_bin`=7 -> outputs 0 next edge and no `upd` on that edge; value 7 returns STAGES+1 cycles after `clr` drops, with one `upd`.
- Macro undefined build -> `optr_bin` stays 0; `upd` fires on every `optr_gray` change, one edge after the change.

Source files
------------

// File: rtl/gray_ptr_sync_pkg.sv
// Shared constants and Gray/binary conversion helpers for pointer synchronisers and FIFO pointer logic.
package gray_ptr_sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int SYNC_WIDTH_MAX  = 16;

  typedef logic [SYNC_WIDTH_MAX-1:0] ptr_t;

  // Narrower pointers are zero-extended by the caller; leading zeros decode to zeros.
  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin[SYNC_WIDTH_MAX-1] = gray[SYNC_WIDTH_MAX-1];
    for (int i = SYNC_WIDTH_MAX-2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_ptr_sync_sync_chain.sv
// N-stage flop chain for one W-bit vector, async active-low reset, sync clear.
// Latency N edges from d_i to q_o; no backpressure.
module sync_chain
  import gray_ptr_sync_pkg::*;
#(
  parameter int W = 4,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (N < SYNC_STAGES_MIN || N > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sync_chain: N out of range");
  end

  // First stage is the one that may go metastable; tools keep it adjacent and unanalysed.
  (* ASYNC_REG = "TRUE" *) logic [W-1:0] meta_q;
  logic [W-1:0] tail_q [N-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      for (int i = 0; i < N-1; i++) tail_q[i] <= '0;
    end else if (clr) begin
      meta_q <= '0;
      for (int i = 0; i < N-1; i++) tail_q[i] <= '0;
    end else begin
      meta_q    <= d_i;
      tail_q[0] <= meta_q;
      for (int i = 1; i < N-1; i++) tail_q[i] <= tail_q[i-1];
    end
  end

  assign q_o = tail_q[N-2];

endmodule

// File: rtl/gray_ptr_sync.sv
// Multi-channel Gray pointer synchroniser; optr_gray after STAGES edges, optr_bin/upd one edge later.
// No backpressure. Macro GRAY_PTR_SYNC_BIN_EN builds the registered binary decode.
module gray_ptr_sync
  import gray_ptr_sync_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int STAGES   = 2,
  parameter int CHANNELS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic [CHANNELS*WIDTH-1:0] iptr_gray,
  output logic [CHANNELS*WIDTH-1:0] optr_gray,
  output logic [CHANNELS*WIDTH-1:0] optr_bin,
  output logic [CHANNELS-1:0]       upd
);

  if (WIDTH < 2 || WIDTH > SYNC_WIDTH_MAX) begin : g_bad_width
    $error("gray_ptr_sync: WIDTH out of range");
  end
  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("gray_ptr_sync: STAGES out of range");
  end
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("gray_ptr_sync: CHANNELS out of range");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] gray_c;
    logic             upd_q;

    sync_chain #(
      .W (WIDTH),
      .N (STAGES)
    ) u_chain (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .d_i (iptr_gray[c*WIDTH +: WIDTH]),
      .q_o (gray_c)
    );

    assign optr_gray[c*WIDTH +: WIDTH] = gray_c;

`ifdef GRAY_PTR_SYNC_BIN_EN
    ptr_t             bin_d;
    logic [WIDTH-1:0] bin_q;

    assign bin_d = gray2bin(ptr_t'(gray_c));

    // upd rises on the same edge that loads the new binary value.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        bin_q <= '0;
        upd_q <= 1'b0;
      end else if (clr) begin
        bin_q <= '0;
        upd_q <= 1'b0;
      end else begin
        bin_q <= bin_d[WIDTH-1:0];
        upd_q <= (bin_d != ptr_t'(bin_q));
      end
    end

    assign optr_bin[c*WIDTH +: WIDTH] = bin_q;
`else
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        prev_q <= '0;
        upd_q  <= 1'b0;
      end else if (clr) begin
        prev_q <= '0;
        upd_q  <= 1'b0;
      end else begin
        prev_q <= gray_c;
        upd_q  <= (gray_c != prev_q);
      end
    end

    assign optr_bin[c*WIDTH +: WIDTH] = '0;
`endif

    assign upd[c] = upd_q;
  end

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench for gray_ptr_sync: reset, Gray count with wrap, STAGES 3/4 latency, two channels, clr.
module tb_gray_ptr_sync;

`ifdef GRAY_PTR_SYNC_BIN_EN
  localparam bit BIN_EN = 1'b1;
`else
  localparam bit BIN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       clr;
  logic [7:0] a_in, a_gray, a_bin;
  logic [1:0] a_upd;
  logic [3:0] s3_in, s3_gray, s3_bin;
  logic       s3_upd;
  logic [3:0] s4_in, s4_gray, s4_bin;
  logic       s4_upd;

  int tests = 0;
  int fails = 0;

  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_ptr_sync #(.WIDTH(4), .STAGES(2), .CHANNELS(2)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .iptr_gray(a_in),
    .optr_gray(a_gray), .optr_bin(a_bin), .upd(a_upd));

  gray_ptr_sync #(.WIDTH(4), .STAGES(3), .CHANNELS(1)) u_dut_s3 (
    .clk(clk), .rst(rst), .clr(clr), .iptr_gray(s3_in),
    .optr_gray(s3_gray), .optr_bin(s3_bin), .upd(s3_upd));

  gray_ptr_sync #(.WIDTH(4), .STAGES(4), .CHANNELS(1)) u_dut_s4 (
    .clk(clk), .rst(rst), .clr(clr), .iptr_gray(s4_in),
    .optr_gray(s4_gray), .optr_bin(s4_bin), .upd(s4_upd));

  task automatic test_reset();
    int n_g = 0, n_u = 0, pulses = 0;
    logic [3:0] bin_u = '0;
    rst = 1'b1; clr = 1'b0; a_in = '0; s3_in = '0; s4_in = '0;
    #1 rst = 1'b0;
    #1;
    tests++;
    if (a_gray !== 8'h0 || a_bin !== 8'h0 || a_upd !== 2'b0) begin
      fails++; $display("FAIL reset_state: gray=%h bin=%h upd=%b, want all 0", a_gray, a_bin, a_upd);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    a_in[3:0] = 4'b0110;
    repeat (6) @(posedge clk);
    #1;
    tests++;
    if (a_gray[3:0] !== 4'b0110) begin
      fails++; $display("FAIL pre_reset_gray: got %b, want 0110", a_gray[3:0]);
    end
    #1 rst = 1'b0;
    #1;
    tests++;
    if (a_gray !== 8'h0) begin fails++; $display("FAIL async_reset_gray: got %h, want 00", a_gray); end
    tests++;
    if (a_bin !== 8'h0) begin fails++; $display("FAIL async_reset_bin: got %h, want 00", a_bin); end
    tests++;
    if (a_upd !== 2'b0) begin fails++; $display("FAIL async_reset_upd: got %b, want 00", a_upd); end
    @(negedge clk);
    rst = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (n_g == 0 && a_gray[3:0] == 4'b0110) n_g = n;
      if (a_upd[0]) begin
        pulses++;
        if (n_u == 0) begin n_u = n; bin_u = a_bin[3:0]; end
      end
    end
    tests++;
    if (n_g != 2 && n_g != 3) begin fails++; $display("FAIL rst_gray_latency: got %0d, want 2 or 3", n_g); end
    tests++;
    if (n_u != n_g + 1) begin fails++; $display("FAIL rst_upd_latency: got %0d, want %0d", n_u, n_g + 1); end
    tests++;
    if (pulses != 1) begin fails++; $display("FAIL rst_upd_pulses: got %0d, want 1", pulses); end
    tests++;
    if (bin_u !== (BIN_EN ? 4'd4 : 4'd0)) begin
      fails++; $display("FAIL rst_bin: got %0d, want %0d", bin_u, BIN_EN ? 4 : 0);
    end
  endtask

  task automatic test_gray_count();
    int pulses = 0, seq_err = 0;
    logic [3:0] seen, exp_v;
    @(negedge clk);
    a_in[3:0] = 4'h0;
    repeat (8) @(negedge clk);
    fork
      begin
        for (int i = 1; i <= 16; i++) begin
          a_in[3:0] = gray_tab[i % 16];
          repeat (3) @(negedge clk);
        end
      end
      begin
        for (int cyc = 0; cyc < 16*3 + 6; cyc++) begin
          @(posedge clk); #1;
          if (a_upd[0]) begin
            seen  = BIN_EN ? a_bin[3:0] : a_gray[3:0];
            exp_v = BIN_EN ? 4'((pulses + 1) % 16) : gray_tab[(pulses + 1) % 16];
            if (seen !== exp_v) seq_err++;
            pulses++;
          end
        end
      end
    join
    tests++;
    if (pulses != 16) begin fails++; $display("FAIL count_upd_pulses: got %0d, want 16", pulses); end
    tests++;
    if (seq_err != 0) begin fails++; $display("FAIL count_sequence: %0d wrong values, want 0", seq_err); end
    tests++;
    if (a_gray[3:0] !== 4'h0 || a_bin[3:0] !== 4'h0) begin
      fails++; $display("FAIL count_wrap: gray=%b bin=%0d, want 0000/0", a_gray[3:0], a_bin[3:0]);
    end
  endtask

  task automatic test_stages();
    int g3 = 0, u3 = 0, g4 = 0, u4 = 0;
    logic [3:0] b3 = '0, b4 = '0;
    @(negedge clk);
    s3_in = 4'b0001;
    s4_in = 4'b0001;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (g3 == 0 && s3_gray == 4'b0001) g3 = n;
      if (u3 == 0 && s3_upd) begin u3 = n; b3 = s3_bin; end
      if (g4 == 0 && s4_gray == 4'b0001) g4 = n;
      if (u4 == 0 && s4_upd) begin u4 = n; b4 = s4_bin; end
    end
    tests++;
    if (g3 != 3 && g3 != 4) begin fails++; $display("FAIL s3_gray_latency: got %0d, want 3 or 4", g3); end
    tests++;
    if (u3 != g3 + 1) begin fails++; $display("FAIL s3_upd_latency: got %0d, want %0d", u3, g3 + 1); end
    tests++;
    if (b3 !== (BIN_EN ? 4'd1 : 4'd0)) begin fails++; $display("FAIL s3_bin: got %0d, want %0d", b3, BIN_EN ? 1 : 0); end
    tests++;
    if (g4 != 4 && g4 != 5) begin fails++; $display("FAIL s4_gray_latency: got %0d, want 4 or 5", g4); end
    tests++;
    if (u4 != g4 + 1) begin fails++; $display("FAIL s4_upd_latency: got %0d, want %0d", u4, g4 + 1); end
    tests++;
    if (b4 !== (BIN_EN ? 4'd1 : 4'd0)) begin fails++; $display("FAIL s4_bin: got %0d, want %0d", b4, BIN_EN ? 1 : 0); end
  endtask

  task automatic test_two_channels();
    int both = 0, partial = 0;
    @(negedge clk);
    a_in = {4'b0111, 4'b1101};
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (a_upd == 2'b11) both++;
      else if (a_upd != 2'b00) partial++;
    end
    tests++;
    if (both != 1) begin fails++; $display("FAIL dual_upd_both: got %0d cycles, want 1", both); end
    tests++;
    if (partial != 0) begin fails++; $display("FAIL dual_upd_split: got %0d cycles, want 0", partial); end
    tests++;
    if (a_gray !== 8'b0111_1101) begin fails++; $display("FAIL dual_gray: got %b, want 01111101", a_gray); end
    tests++;
    if (a_bin !== (BIN_EN ? 8'h59 : 8'h00)) begin
      fails++; $display("FAIL dual_bin: got %h, want %h", a_bin, BIN_EN ? 8'h59 : 8'h00);
    end
  endtask

  task automatic test_clr();
    int n_u = 0, pulses = 0;
    logic [3:0] exp_b;
    logic [3:0] bin_u = '0;
    exp_b = BIN_EN ? 4'd7 : 4'd0;
    @(negedge clk);
    a_in[3:0] = 4'b0100;
    repeat (8) @(negedge clk);
    tests++;
    if (a_gray[3:0] !== 4'b0100 || a_bin[3:0] !== exp_b) begin
      fails++; $display("FAIL clr_setup: gray=%b bin=%0d, want 0100/%0d", a_gray[3:0], a_bin[3:0], exp_b);
    end
    clr = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (a_gray !== 8'h0 || a_bin !== 8'h0 || a_upd !== 2'b0) begin
      fails++; $display("FAIL clr_edge: gray=%h bin=%h upd=%b, want all 0", a_gray, a_bin, a_upd);
    end
    @(negedge clk);
    clr = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (a_upd[0]) begin
        pulses++;
        if (n_u == 0) begin n_u = n; bin_u = a_bin[3:0]; end
      end
    end
    tests++;
    if (n_u != 3 && n_u != 4) begin fails++; $display("FAIL clr_refill_latency: got %0d, want 3 or 4", n_u); end
    tests++;
    if (pulses != 1) begin fails++; $display("FAIL clr_refill_pulses: got %0d, want 1", pulses); end
    tests++;
    if (bin_u !== exp_b || a_gray[3:0] !== 4'b0100) begin
      fails++; $display("FAIL clr_refill_value: bin=%0d gray=%b, want %0d/0100", bin_u, a_gray[3:0], exp_b);
    end
    // clr lands on the edge where upd would otherwise fire.
    @(negedge clk);
    a_in[3:0] = 4'b0011;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (a_upd[0] !== 1'b0 || a_gray[3:0] !== 4'h0) begin
      fails++; $display("FAIL clr_collide: upd=%b gray=%b, want 0/0000", a_upd[0], a_gray[3:0]);
    end
    @(negedge clk);
    clr = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_gray_count();
    test_stages();
    test_two_channels();
    test_clr();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
